stage3_fetch_stage: RTL
=======================

STAGE3_FETCH_STAGE -- requirements
Module: stage3_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have clock and reset: CLK in 1, the only clock; RST in 1, asynchronous active-high reset.
REQ-003 SHALL have imem_ren out 1 (fetch request) and imem_addr out 32 (fetch address, held stable while busy).
REQ-004 SHALL have imem_busy in 1 (1 = request not complete), imem_rdata in 32 (instruction) and imem_fault in 1 (access fault, valid when !imem_busy).
REQ-005 SHALL have redirect in 1 (PC override from the downstream stage) and redirect_addr in 32 (the new PC).
REQ-006 SHALL have fe_stall in 1 (hold the output register) and fe_flush in 1 (clear the output register).
REQ-007 SHALL have registered outputs to the execute stage: out_valid 1, out_pc 32, out_pc4 32, out_instr 32, out_prediction 1, out_predicted_address 32, out_mal_insn 1, out_fault_insn 1, out_badaddr 32.

Function
REQ-008 SHALL implement states FETCH, HOLD, DISCARD and WAIT_REDIR, plus registers pc, inflight_addr and held_instr.
REQ-009 FETCH: imem_ren=1, imem_addr=pc, inflight_addr<=pc; in every other state imem_addr=inflight_addr.
REQ-010 FETCH completion (!imem_busy), no redirect, no stall, no flush: load the output register (valid=1, pc, pc4=pc+4, instr=imem_rdata), set pc<=next_pc and stay in FETCH. Latency is 1 cycle from completion to out_valid.
REQ-011 FETCH completion with fe_stall=1 and no redirect: held_instr<=imem_rdata and go to HOLD with imem_ren=0. When fe_stall drops, load the output from held_instr, pc<=next_pc and return to FETCH.
REQ-012 Redirect in FETCH while imem_busy: pc<=redirect_addr and go to DISCARD. DISCARD keeps imem_ren=1 and imem_addr=inflight_addr; on completion it drops the data and goes to FETCH.
REQ-013 Redirect in FETCH at completion, in HOLD, or in WAIT_REDIR: drop any data, pc<=redirect_addr and go to FETCH next cycle.
REQ-014 A redirect in DISCARD SHALL overwrite pc and leave the state in DISCARD.
REQ-015 Misaligned pc in FETCH (pc[1:0]!=0): no request (imem_ren=0). Load the output with valid=1, mal_insn=1, instr=0 and badaddr=pc, then go to WAIT_REDIR.
REQ-016 Completion with imem_fault=1: load the output with valid=1, fault_insn=1, instr=0 and badaddr=pc, then go to WAIT_REDIR. WAIT_REDIR issues no requests until a redirect.
REQ-017 Output register priority: fe_stall holds all fields; otherwise fe_flush clears all fields to 0; otherwise load as above; otherwise valid<=0.
REQ-018 fe_flush without redirect at completion: data dropped, pc not advanced, the same address is refetched.
REQ-019 Address arithmetic SHALL be modulo 2^32 (pc+4 wraps 32'hFFFF_FFFC to 0).
REQ-020 Without prediction: next_pc=pc+4, out_prediction=0, out_predicted_address=pc+4.

Reset
REQ-021 While RST=1 (asynchronous): pc=RESET_PC, state=FETCH, inflight_addr=RESET_PC, held_instr=0, and all out_* fields=0.
REQ-022 First request SHALL issue in the first cycle after RST deasserts. Reset mid-request abandons the request with no output.

Configuration
REQ-023 Macro STAGE3_FETCH_BTFN_EN SHALL enable backward-taken/forward-not-taken prediction.
REQ-024 With the macro: instr[6:0]=7'b1100011 and instr[31]=1 gives next_pc=pc+sext(imm_SB), out_prediction=1 and out_predicted_address=target; otherwise REQ-020 applies.
REQ-025 Without the macro: REQ-020 behaviour and no prediction logic.

Verification
REQ-026 Reset release, memory returns 32'h00000013 with 0-cycle busy at 8000_0000 and 8000_0004 -> out_valid=1, out_pc=8000_0000 then 8000_0004, out_pc4=8000_0004.
REQ-027 Redirect to 32'h8000_0100 while busy on 8000_0008 -> the 8000_0008 data never reaches the output; next request addr=8000_0100.
REQ-028 fe_stall high for 3 cycles at completion -> output held, imem_ren=0, held instruction delivered the cycle after fe_stall drops.
REQ-029 Redirect to 32'h8000_0002 -> no request; out_mal_insn=1, out_badaddr=8000_0002; no further requests until the next redirect.
REQ-030 With STAGE3_FETCH_BTFN_EN, beq x0,x0,-8 at 8000_0010 -> out_prediction=1, out_predicted_address=8000_0008, next request 8000_0008; without the macro, next request is 8000_0014.

Source files
------------

// File: rtl/stage3_fetch_stage.sv
// Instruction fetch stage: issues imem requests, follows redirects, and registers fetched words for execute.
// Define STAGE3_FETCH_BTFN_EN to enable backward-taken/forward-not-taken branch prediction.
module stage3_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        imem_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        fe_stall,
    input  logic        fe_flush,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_instr,
    output logic        out_prediction,
    output logic [31:0] out_predicted_address,
    output logic        out_mal_insn,
    output logic        out_fault_insn,
    output logic [31:0] out_badaddr,
    output logic [1:0]  dbg_state
);

    // Memory handshake: a request is presented while imem_ren=1 and completes in the
    // first cycle imem_busy=0; imem_addr stays constant until that completion.
    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        HOLD       = 2'd1,
        DISCARD    = 2'd2,
        WAIT_REDIR = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] inflight_addr;
    logic [31:0] held_instr;
    logic        held_we;
    logic        load_en, load_mal, load_fault;
    logic [31:0] load_instr;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        pred;

    assign dbg_state  = state;
    assign seq_pc     = pc + 32'd4;
    assign load_instr = (state == HOLD) ? held_instr : imem_rdata;

`ifdef STAGE3_FETCH_BTFN_EN
    logic [31:0] imm_sb;
    assign imm_sb  = {{20{load_instr[31]}}, load_instr[7], load_instr[30:25],
                      load_instr[11:8], 1'b0};
    assign pred    = (load_instr[6:0] == 7'b1100011) && load_instr[31];
    assign next_pc = pred ? (pc + imm_sb) : seq_pc;
`else
    assign pred    = 1'b0;
    assign next_pc = seq_pc;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        imem_ren   = 1'b0;
        imem_addr  = inflight_addr;
        load_en    = 1'b0;
        load_mal   = 1'b0;
        load_fault = 1'b0;
        held_we    = 1'b0;
        case (state)
            FETCH: begin
                imem_addr = pc;
                if (pc[1:0] != 2'b00) begin
                    // Misaligned: never touch memory, report once and park.
                    if (redirect) begin
                        pc_next = redirect_addr;
                    end else if (!fe_stall && !fe_flush) begin
                        load_en    = 1'b1;
                        load_mal   = 1'b1;
                        state_next = WAIT_REDIR;
                    end
                end else begin
                    imem_ren = 1'b1;
                    if (redirect) begin
                        pc_next = redirect_addr;
                        if (imem_busy) state_next = DISCARD;
                    end else if (!imem_busy) begin
                        if (fe_stall) begin
                            // A faulting word under stall is simply refetched later.
                            if (!imem_fault) begin
                                held_we    = 1'b1;
                                state_next = HOLD;
                            end
                        end else if (!fe_flush) begin
                            load_en = 1'b1;
                            if (imem_fault) begin
                                load_fault = 1'b1;
                                state_next = WAIT_REDIR;
                            end else begin
                                pc_next = next_pc;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_addr;
                    state_next = FETCH;
                end else if (!fe_stall) begin
                    state_next = FETCH;
                    if (!fe_flush) begin
                        load_en = 1'b1;
                        pc_next = next_pc;
                    end
                end
            end
            DISCARD: begin
                imem_ren = 1'b1;
                if (redirect) pc_next = redirect_addr;
                else if (!imem_busy) state_next = FETCH;
            end
            WAIT_REDIR: begin
                if (redirect) begin
                    pc_next    = redirect_addr;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            inflight_addr <= RESET_PC;
            held_instr    <= 32'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH) inflight_addr <= pc;
            if (held_we) held_instr <= imem_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid             <= 1'b0;
            out_pc                <= 32'd0;
            out_pc4               <= 32'd0;
            out_instr             <= 32'd0;
            out_prediction        <= 1'b0;
            out_predicted_address <= 32'd0;
            out_mal_insn          <= 1'b0;
            out_fault_insn        <= 1'b0;
            out_badaddr           <= 32'd0;
        end else if (fe_stall) begin
            out_valid <= out_valid;
        end else if (fe_flush) begin
            out_valid             <= 1'b0;
            out_pc                <= 32'd0;
            out_pc4               <= 32'd0;
            out_instr             <= 32'd0;
            out_prediction        <= 1'b0;
            out_predicted_address <= 32'd0;
            out_mal_insn          <= 1'b0;
            out_fault_insn        <= 1'b0;
            out_badaddr           <= 32'd0;
        end else if (load_en) begin
            out_valid             <= 1'b1;
            out_pc                <= pc;
            out_pc4               <= seq_pc;
            out_instr             <= (load_mal || load_fault) ? 32'd0 : load_instr;
            out_prediction        <= (load_mal || load_fault) ? 1'b0 : pred;
            out_predicted_address <= (load_mal || load_fault) ? seq_pc : next_pc;
            out_mal_insn          <= load_mal;
            out_fault_insn        <= load_fault;
            out_badaddr           <= (load_mal || load_fault) ? pc : 32'd0;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
